// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode and condition-code encodings, flag bit
// positions, and the flag-op / branch-condition helpers used by the sequencer.
package alu_pkg;

   localparam logic [5:0] OP_MOV = 6'b000111;
   localparam logic [5:0] OP_LSR = 6'b001000;
   localparam logic [5:0] OP_LSL = 6'b001001;
   localparam logic [5:0] OP_RSR = 6'b001010;
   localparam logic [5:0] OP_RSL = 6'b001011;
   localparam logic [5:0] OP_AND = 6'b001100;
   localparam logic [5:0] OP_OR  = 6'b001101;
   localparam logic [5:0] OP_XOR = 6'b001110;
   localparam logic [5:0] OP_NOT = 6'b001111;
   localparam logic [5:0] OP_ADD = 6'b010001;
   localparam logic [5:0] OP_SUB = 6'b010010;
   localparam logic [5:0] OP_MUL = 6'b010011;
   localparam logic [5:0] OP_DIV = 6'b010100;
   localparam logic [5:0] OP_MOD = 6'b010101;
   localparam logic [5:0] OP_CMP = 6'b010110;
   localparam logic [5:0] OP_TST = 6'b010111;
   localparam logic [5:0] OP_INC = 6'b011000;
   localparam logic [5:0] OP_DEC = 6'b011001;

   localparam logic [3:0] CC_AL = 4'h0;
   localparam logic [3:0] CC_EQ = 4'h1;
   localparam logic [3:0] CC_NE = 4'h2;
   localparam logic [3:0] CC_CS = 4'h3;
   localparam logic [3:0] CC_CC = 4'h4;
   localparam logic [3:0] CC_MI = 4'h5;
   localparam logic [3:0] CC_PL = 4'h6;
   localparam logic [3:0] CC_VS = 4'h7;
   localparam logic [3:0] CC_VC = 4'h8;
   localparam logic [3:0] CC_HI = 4'h9;
   localparam logic [3:0] CC_LS = 4'hA;
   localparam logic [3:0] CC_GE = 4'hB;
   localparam logic [3:0] CC_LT = 4'hC;
   localparam logic [3:0] CC_GT = 4'hD;
   localparam logic [3:0] CC_LE = 4'hE;
   localparam logic [3:0] CC_NV = 4'hF;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   function automatic logic is_flag_op(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_CMP, OP_TST, OP_INC, OP_DEC,
         OP_LSR, OP_LSL, OP_RSR, OP_RSL, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV:
            return 1'b1;
         default:
            return 1'b0;
      endcase
   endfunction

   // f is {N,Z,C,V}; C carries borrow semantics after SUB/CMP.
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      n = f[FLAG_N];
      z = f[FLAG_Z];
      c = f[FLAG_C];
      v = f[FLAG_V];
      case (cond)
         CC_AL:   return 1'b1;
         CC_EQ:   return z;
         CC_NE:   return !z;
         CC_CS:   return c;
         CC_CC:   return !c;
         CC_MI:   return n;
         CC_PL:   return !n;
         CC_VS:   return v;
         CC_VC:   return !v;
         CC_HI:   return !c && !z;
         CC_LS:   return c || z;
         CC_GE:   return n == v;
         CC_LT:   return n != v;
         CC_GT:   return !z && (n == v);
         CC_LE:   return z || (n != v);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/flag_unit_if.sv
// Sequencer <-> flag unit bus: ALU flag inputs, flag write, stack and branch
// requests, and the flag/branch/stack status returned.
interface flag_unit_if #(parameter int unsigned DEPTH = 4);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             alu_valid;
   logic             alu_store;
   logic [5:0]       opcode;
   logic             zero_in;
   logic             negative_in;
   logic             overflow_in;
   logic             carry_in;
   logic             flag_wr;
   logic [3:0]       flag_wdata;
   logic             push;
   logic             pop;
   logic             br_valid;
   logic [3:0]       br_cond;
   logic [3:0]       flags;
   logic             br_done;
   logic             br_taken;
   logic [CNT_W-1:0] stack_count;
   logic             stack_full;
   logic             stack_empty;
   logic             err;

   modport master (
      output alu_valid, alu_store, opcode, zero_in, negative_in, overflow_in, carry_in,
      output flag_wr, flag_wdata, push, pop, br_valid, br_cond,
      input  flags, br_done, br_taken, stack_count, stack_full, stack_empty, err
   );

   modport slave (
      input  alu_valid, alu_store, opcode, zero_in, negative_in, overflow_in, carry_in,
      input  flag_wr, flag_wdata, push, pop, br_valid, br_cond,
      output flags, br_done, br_taken, stack_count, stack_full, stack_empty, err
   );
endinterface

// File: rtl/flag_unit_stack.sv
// DEPTH x 4-bit LIFO for saved flags. Callers qualify push/pop; this block
// only guards against overflow/underflow of its own storage.
module flag_stack #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [3:0]                   wdata,
   output logic [3:0]                   rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [3:0]       mem_q [DEPTH];
   logic [3:0]       mem_d [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   // Index by comparison rather than slicing so the count width never has
   // to match the array index width.
   always_comb begin
      rdata = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i + 1) == count_q) rdata = mem_q[i];
      end
   end

   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      if (push && !full) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == count_q) mem_d[i] = wdata;
         end
         count_d = count_q + 1'b1;
      end else if (pop && !empty) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: rtl/flag_unit.sv
// Architectural flag register, flag stack and registered branch evaluation.
// Define FLAG_UNIT_FWD_EN to evaluate branches on the next-state flags.
module flag_unit
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input logic        clk,
   input logic        rst,
   flag_unit_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [3:0]       flags_q, flags_d;
   logic             br_done_q, br_done_d;
   logic             br_taken_q, br_taken_d;
   logic             err_q, err_d;

   logic             collide, do_push, do_pop;
   logic [3:0]       stack_top, alu_flags, eval_flags;
   logic [CNT_W-1:0] stack_count;
   logic             stack_full, stack_empty;

   flag_stack #(.DEPTH(DEPTH)) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (do_push),
      .pop   (do_pop),
      .wdata (flags_q),
      .rdata (stack_top),
      .count (stack_count),
      .full  (stack_full),
      .empty (stack_empty)
   );

   assign collide   = bus.push && bus.pop;
   assign do_push   = bus.push && !bus.pop && !stack_full;
   assign do_pop    = bus.pop && !bus.push && !stack_empty;
   assign alu_flags = {bus.negative_in, bus.zero_in, bus.carry_in, bus.overflow_in};

   always_comb begin
      flags_d = flags_q;
      if (do_pop)
         flags_d = stack_top;
      else if (bus.flag_wr)
         flags_d = bus.flag_wdata;
      else if (bus.alu_valid && !bus.alu_store && is_flag_op(bus.opcode))
         flags_d = alu_flags;
   end

`ifdef FLAG_UNIT_FWD_EN
   assign eval_flags = flags_d;
`else
   assign eval_flags = flags_q;
`endif

   always_comb begin
      err_d      = err_q
                 || collide
                 || (bus.push && !bus.pop && stack_full)
                 || (bus.pop && !bus.push && stack_empty);
      br_done_d  = bus.br_valid;
      br_taken_d = bus.br_valid ? cond_eval(bus.br_cond, eval_flags) : br_taken_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q    <= '0;
         br_done_q  <= 1'b0;
         br_taken_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         flags_q    <= flags_d;
         br_done_q  <= br_done_d;
         br_taken_q <= br_taken_d;
         err_q      <= err_d;
      end
   end

   assign bus.flags       = flags_q;
   assign bus.br_done     = br_done_q;
   assign bus.br_taken    = br_taken_q;
   assign bus.err         = err_q;
   assign bus.stack_count = stack_count;
   assign bus.stack_full  = stack_full;
   assign bus.stack_empty = stack_empty;

endmodule
